// File: rtl/sense_push_ctrl_pkg.sv
// Shared types and defaults for the sense-loop push controller.
package sense_push_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    WAIT_RTZ = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  localparam int DEF_SAMPLE_BITS = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  // bit_cnt must be able to hold SAMPLE_BITS itself (the "full" value)
  function automatic int cnt_width(input int sample_bits);
    return $clog2(sample_bits + 1);
  endfunction

endpackage

// File: rtl/sense_sync.sv
// Multi-flop synchroniser for a single asynchronous level, synchronous active-low reset.
module sense_sync
  import sense_push_ctrl_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nreset) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sense_push_ctrl.sv
// Acknowledges 4-phase pushes from an asynchronous sense loop and assembles
// the bundled sense bits into words delivered over a valid/ready interface.
module sense_push_ctrl
  import sense_push_ctrl_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   enable,
  output logic                   activate_0r,
  input  logic                   push_0r,
  output logic                   push_0a,
  input  logic                   push_0d,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [SAMPLE_BITS-1:0] word_data,
  output logic                   timeout,
  output logic                   busy
);

  localparam int CW = cnt_width(SAMPLE_BITS);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] FULL    = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] LAST    = CW'(SAMPLE_BITS - 1);
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLIM_M1 = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);

  state_t                 state, state_nx;
  logic                   req_s;
  logic                   req_low_seen;
  logic [SW-1:0]          settle_cnt;
  logic [CW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-1:0] shift_reg;
  logic [TW-1:0]          tcnt;
  logic                   full, out_free, capture, hs_done, last_bit, load_out, tcount_en;

  sense_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (push_0r),
    .q      (req_s)
  );

  // A capture needs req_s seen low first, so a request left high across reset is ignored
  assign full      = (bit_cnt == FULL);
  assign out_free  = !word_valid || word_ready;
  assign capture   = (state == WAIT_REQ) && req_s && req_low_seen && !full;
  assign hs_done   = ((state == WAIT_RTZ) || (state == DRAIN)) && push_0a && !req_s;
  assign last_bit  = hs_done && (bit_cnt == LAST);
  assign load_out  = out_free && (full || last_bit);
  assign tcount_en = ((state == WAIT_REQ) && !full) || (state == WAIT_RTZ);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (enable) state_nx = WAIT_REQ;
      WAIT_REQ: begin
        if (capture)      state_nx = enable ? WAIT_RTZ : DRAIN;
        else if (!enable) state_nx = IDLE;
      end
      WAIT_RTZ: begin
        if (!enable)     state_nx = DRAIN;
        else if (!req_s) state_nx = WAIT_REQ;
      end
      DRAIN:    if (!req_s) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      activate_0r  <= 1'b0;
      push_0a      <= 1'b0;
      req_low_seen <= 1'b0;
      settle_cnt   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      word_valid   <= 1'b0;
      word_data    <= '0;
      tcnt         <= '0;
      timeout      <= 1'b0;
    end else begin
      activate_0r <= enable && ((state_nx == WAIT_REQ) || (state_nx == WAIT_RTZ));

      if (capture)     push_0a <= 1'b1;
      else if (!req_s) push_0a <= 1'b0;

      // req_s is only trusted once the synchroniser has refilled after reset
      if (settle_cnt != SETTLED) settle_cnt <= settle_cnt + 1'b1;
      if (capture)                             req_low_seen <= 1'b0;
      else if (!req_s && settle_cnt == SETTLED) req_low_seen <= 1'b1;

      for (int i = 0; i < SAMPLE_BITS; i++) begin
        if (capture && bit_cnt == CW'(i)) shift_reg[i] <= push_0d;
      end

      if (load_out || state_nx == IDLE) bit_cnt <= '0;
      else if (hs_done)                 bit_cnt <= bit_cnt + 1'b1;

      if (load_out) begin
        word_valid <= 1'b1;
        word_data  <= shift_reg;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end

      if (state_nx != state)                 tcnt <= '0;
      else if (tcount_en && tcnt != TLIM)    tcnt <= tcnt + 1'b1;

      if (state == IDLE && state_nx == WAIT_REQ)
        timeout <= 1'b0;
      else if (state_nx == state && tcount_en && tcnt == TLIM_M1)
        timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sense_push_ctrl.sv
// Directed and randomized bench for sense_push_ctrl with a bit-queue word model.
module tb_sense_push_ctrl;

  localparam int SB   = 8;
  localparam int SS   = 2;
  localparam int TO   = 10;
  localparam int MAXW = 64;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          enable = 1'b0;
  logic          activate_0r;
  logic          push_0r = 1'b0;
  logic          push_0a;
  logic          push_0d = 1'b0;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic [SB-1:0] word_data;
  logic          timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int ack_pulses = 0;
  int valid_cycles = 0;
  logic prev_ack = 1'b0;
  logic rand_ready = 1'b0;
  logic [SB-1:0] got_q[$];
  logic [SB-1:0] exp_q[$];
  logic          bit_q[$];

  always #5 clk = ~clk;

  sense_push_ctrl #(
    .SAMPLE_BITS (SB),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .enable      (enable),
    .activate_0r (activate_0r),
    .push_0r     (push_0r),
    .push_0a     (push_0a),
    .push_0d     (push_0d),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .timeout     (timeout),
    .busy        (busy)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs in effect now are what the coming posedge samples, so log transfers first
  task automatic tick();
    if (word_valid === 1'b1 && word_ready === 1'b1) got_q.push_back(word_data);
    @(negedge clk);
    if (push_0a === 1'b1 && prev_ack === 1'b0) ack_pulses++;
    prev_ack = push_0a;
    if (word_valid === 1'b1) valid_cycles++;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int n = 0;
    while (push_0a !== level && n < MAXW) begin
      tick();
      n++;
    end
    check_output(tag, 32'(push_0a), 32'(level));
  endtask

  task automatic push_bit(input logic b, output logic ok);
    int n;
    ok = 1'b1;
    push_0d = b;
    push_0r = 1'b1;
    n = 0;
    while (push_0a !== 1'b1 && n < MAXW) begin
      tick();
      n++;
    end
    if (push_0a !== 1'b1) ok = 1'b0;
    push_0r = 1'b0;
    n = 0;
    while (push_0a !== 1'b0 && n < MAXW) begin
      tick();
      n++;
    end
    if (push_0a !== 1'b0) ok = 1'b0;
  endtask

  // Reference model: every SB accepted bits form one word, first bit at bit 0
  task automatic offer(input logic b);
    logic ok;
    logic [SB-1:0] w;
    push_bit(b, ok);
    check_output("push_handshake", 32'(ok), 32'd1);
    bit_q.push_back(b);
    if (bit_q.size() == SB) begin
      w = '0;
      for (int i = 0; i < SB; i++) w[i] = bit_q[i];
      exp_q.push_back(w);
      bit_q.delete();
    end
  endtask

  task automatic compare_words(input string tag);
    check_output({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_output(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_activate"}, 32'(activate_0r), 32'd0);
    check_output({tag, "_ack"}, 32'(push_0a), 32'd0);
    check_output({tag, "_valid"}, 32'(word_valid), 32'd0);
    check_output({tag, "_data"}, 32'(word_data), 32'd0);
    check_output({tag, "_timeout"}, 32'(timeout), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_stimulus();
    logic assembly_bits [SB];
    int pulses;
    assembly_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Power-up reset
    nreset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    nreset = 1'b1;
    repeat (4) tick();

    // Word assembly with a ready consumer
    word_ready = 1'b1;
    enable = 1'b1;
    tick();
    check_output("enable_activate", 32'(activate_0r), 32'd1);
    check_output("enable_busy", 32'(busy), 32'd1);
    ack_pulses = 0;
    valid_cycles = 0;
    for (int i = 0; i < SB; i++) offer(assembly_bits[i]);
    repeat (6) tick();
    check_output("assembly_acks", 32'(ack_pulses), 32'd8);
    check_output("assembly_valid_cycles", 32'(valid_cycles), 32'd1);
    if (got_q.size() > 0) check_output("assembly_4d", 32'(got_q[0]), 32'h4d);
    compare_words("assembly");

    // Back-pressure: two words fill output and shift registers
    word_ready = 1'b0;
    for (int i = 0; i < 2 * SB; i++) offer(1'($urandom_range(0, 1)));
    pulses = ack_pulses;
    push_0d = 1'($urandom_range(0, 1));
    push_0r = 1'b1;
    repeat (20) tick();
    check_output("bp_no_ack", 32'(ack_pulses), 32'(pulses));
    check_output("bp_ack_low", 32'(push_0a), 32'd0);
    check_output("bp_valid", 32'(word_valid), 32'd1);
    check_output("bp_first_word", 32'(word_data), 32'(exp_q[0]));
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check_output("bp_swap_valid", 32'(word_valid), 32'd1);
    check_output("bp_second_word", 32'(word_data), 32'(exp_q[1]));
    wait_ack(1'b1, "bp_17th_ack");
    bit_q.push_back(push_0d);
    push_0r = 1'b0;
    wait_ack(1'b0, "bp_17th_release");
    word_ready = 1'b1;
    repeat (3) tick();
    compare_words("backpressure");
    enable = 1'b0;
    repeat (4) tick();
    bit_q.delete();

    // Randomized bits, peer gaps and consumer readiness
    enable = 1'b1;
    tick();
    rand_ready = 1'b1;
    for (int i = 0; i < 3 * SB; i++) begin
      offer(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    repeat (6) tick();
    compare_words("random");

    // Timeout: entry cycle plus TO counting cycles in WAIT_REQ
    enable = 1'b0;
    repeat (3) tick();
    bit_q.delete();
    enable = 1'b1;
    for (int k = 1; k <= TO + 3; k++) begin
      tick();
      check_output("timeout_cycle", 32'(timeout), 32'(k > TO));
    end
    repeat (20) tick();
    check_output("timeout_sticky", 32'(timeout), 32'd1);
    enable = 1'b0;
    repeat (2) tick();
    check_output("timeout_held_idle", 32'(timeout), 32'd1);
    enable = 1'b1;
    tick();
    check_output("timeout_cleared", 32'(timeout), 32'd0);

    // Disable while the acknowledge is high
    push_0d = 1'b1;
    push_0r = 1'b1;
    wait_ack(1'b1, "dis_ack_rise");
    enable = 1'b0;
    tick();
    check_output("dis_activate", 32'(activate_0r), 32'd0);
    check_output("dis_ack_held", 32'(push_0a), 32'd1);
    repeat (3) tick();
    check_output("dis_ack_still", 32'(push_0a), 32'd1);
    check_output("dis_busy", 32'(busy), 32'd1);
    push_0r = 1'b0;
    wait_ack(1'b0, "dis_ack_fall");
    check_output("dis_idle", 32'(busy), 32'd0);
    bit_q.delete();
    enable = 1'b1;
    tick();
    for (int i = 0; i < SB; i++) offer(1'($urandom_range(0, 1)));
    repeat (6) tick();
    compare_words("after_disable");

    // Reset while the acknowledge is high, request left asserted
    push_0d = 1'b1;
    push_0r = 1'b1;
    wait_ack(1'b1, "rst_ack_rise");
    nreset = 1'b0;
    tick();
    check_all_zero("midreset");
    nreset = 1'b1;
    pulses = ack_pulses;
    repeat (12) tick();
    check_output("rst_no_capture", 32'(ack_pulses), 32'(pulses));
    push_0r = 1'b0;
    repeat (4) tick();
    bit_q.delete();
    for (int i = 0; i < SB; i++) offer(1'($urandom_range(0, 1)));
    repeat (6) tick();
    compare_words("after_reset");
  endtask

  initial begin
    apply_stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
